// File: rtl/onehot_to_index_pkg.sv
// Shared constants and helpers for the one-hot to binary index encoder.
package onehot_to_index_pkg;

    // Bit-numbering conventions accepted by the DIRECTION parameter.
    localparam string DIR_LSB0 = "LSB0";
    localparam string DIR_MSB0 = "MSB0";

    // Position reported for input bit bit_idx under the chosen numbering.
    function automatic int unsigned bit_position(
        input int unsigned bit_idx,
        input int unsigned num_signals,
        input bit          msb0
    );
        return msb0 ? (num_signals - 1 - bit_idx) : bit_idx;
    endfunction

endpackage

// File: rtl/onehot_to_index_comb.sv
// Purely combinational one-hot encoder: OR of per-bit index codes, plus
// any-set and multi-hot detection. No clock, no reset.
module onehot_to_index_comb
    import onehot_to_index_pkg::*;
#(
    parameter int    NUM_SIGNALS = 4,
    parameter string DIRECTION   = DIR_LSB0,
    parameter int    INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
    input  logic [NUM_SIGNALS-1:0] one_hot,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   any_set,
    output logic                   multi_hot
);

    localparam bit MSB0 = (DIRECTION == DIR_MSB0);

    // Per-bit code, gated by its request bit; zero when the bit is clear.
    logic [NUM_SIGNALS-1:0][INDEX_WIDTH-1:0] lane_code;

    // Subtrahend for the clear-lowest-set-bit trick.
    localparam logic [NUM_SIGNALS-1:0] ONE = {{(NUM_SIGNALS-1){1'b0}}, 1'b1};

    genvar i;
    generate
        for (i = 0; i < NUM_SIGNALS; i++) begin : g_lane
            // Codes are truncated to INDEX_WIDTH; only matters if the
            // index width was overridden narrower than clog2.
            localparam int unsigned            POS  = bit_position(i, NUM_SIGNALS, MSB0);
            localparam logic [INDEX_WIDTH-1:0] CODE = INDEX_WIDTH'(POS);
            assign lane_code[i] = one_hot[i] ? CODE : '0;
        end
    endgenerate

    // Flat OR of all gated codes; deliberately no priority chain so the
    // multi-hot result is the OR of the individual indices.
    always_comb begin
        index = '0;
        for (int k = 0; k < NUM_SIGNALS; k++) begin
            index = index | lane_code[k];
        end
    end

    // Any request present.
    always_comb begin
        any_set = |one_hot;
    end

    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    always_comb begin
        multi_hot = ((one_hot & (one_hot - ONE)) != '0);
    end

endmodule

// File: rtl/onehot_to_index.sv
// One-hot to binary index encoder. Zero-latency combinational outputs plus
// a registered copy and a sticky multi-hot error flag for debug.
module onehot_to_index
    import onehot_to_index_pkg::*;
#(
    parameter int    NUM_SIGNALS      = 4,
    parameter string DIRECTION        = DIR_LSB0,
    parameter int    INDEX_WIDTH      = $clog2(NUM_SIGNALS),
    // Set to 0 in environments that drive multi-hot inputs on purpose.
    parameter bit    ASSERT_MULTI_HOT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SIGNALS-1:0] one_hot,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   any_set,
    output logic                   multi_hot,
    output logic [INDEX_WIDTH-1:0] index_r,
    output logic                   any_set_r,
    output logic                   error_sticky
);

    onehot_to_index_comb #(
        .NUM_SIGNALS (NUM_SIGNALS),
        .DIRECTION   (DIRECTION),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_comb (
        .one_hot   (one_hot),
        .index     (index),
        .any_set   (any_set),
        .multi_hot (multi_hot)
    );

    // Registered copy of the encoder result; captured every edge, no enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_r   <= '0;
            any_set_r <= 1'b0;
        end else begin
            index_r   <= index;
            any_set_r <= any_set;
        end
    end

    // Sticky error: latches any multi-hot seen at an edge until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_sticky <= 1'b0;
        end else if (multi_hot) begin
            error_sticky <= 1'b1;
        end
    end

    generate
        if (ASSERT_MULTI_HOT) begin : g_chk
            // Flag illegal multi-hot requests outside reset.
            always @(posedge clk) begin
                if (!reset) begin
                    assert (!multi_hot)
                        else $error("onehot_to_index: multi-hot input %b", one_hot);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_onehot_to_index.sv
// Randomized self-checking bench for onehot_to_index, several configurations.
module tb_onehot_to_index;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] oh8;
    logic [4:0] oh5;
    logic [1:0] oh2;

    logic [2:0] l8_idx, l8_idx_r, m8_idx, m8_idx_r;
    logic       l8_any, l8_multi, l8_any_r, l8_err;
    logic       m8_any, m8_multi, m8_any_r, m8_err;
    logic [2:0] l5_idx, l5_idx_r, m5_idx, m5_idx_r;
    logic       l5_any, l5_multi, l5_any_r, l5_err;
    logic       m5_any, m5_multi, m5_any_r, m5_err;
    logic [0:0] l2_idx, l2_idx_r;
    logic       l2_any, l2_multi, l2_any_r, l2_err;

    int errors = 0;
    int checks = 0;
    bit sticky8;

    always #5 clk = ~clk;

    onehot_to_index #(.NUM_SIGNALS(8), .DIRECTION("LSB0"), .ASSERT_MULTI_HOT(1'b0)) u_l8 (
        .clk(clk), .reset(reset), .one_hot(oh8), .index(l8_idx), .any_set(l8_any),
        .multi_hot(l8_multi), .index_r(l8_idx_r), .any_set_r(l8_any_r), .error_sticky(l8_err));
    onehot_to_index #(.NUM_SIGNALS(8), .DIRECTION("MSB0"), .ASSERT_MULTI_HOT(1'b0)) u_m8 (
        .clk(clk), .reset(reset), .one_hot(oh8), .index(m8_idx), .any_set(m8_any),
        .multi_hot(m8_multi), .index_r(m8_idx_r), .any_set_r(m8_any_r), .error_sticky(m8_err));
    onehot_to_index #(.NUM_SIGNALS(5), .DIRECTION("LSB0")) u_l5 (
        .clk(clk), .reset(reset), .one_hot(oh5), .index(l5_idx), .any_set(l5_any),
        .multi_hot(l5_multi), .index_r(l5_idx_r), .any_set_r(l5_any_r), .error_sticky(l5_err));
    onehot_to_index #(.NUM_SIGNALS(5), .DIRECTION("MSB0")) u_m5 (
        .clk(clk), .reset(reset), .one_hot(oh5), .index(m5_idx), .any_set(m5_any),
        .multi_hot(m5_multi), .index_r(m5_idx_r), .any_set_r(m5_any_r), .error_sticky(m5_err));
    onehot_to_index #(.NUM_SIGNALS(2), .DIRECTION("LSB0")) u_l2 (
        .clk(clk), .reset(reset), .one_hot(oh2), .index(l2_idx), .any_set(l2_any),
        .multi_hot(l2_multi), .index_r(l2_idx_r), .any_set_r(l2_any_r), .error_sticky(l2_err));

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: OR of the numeric positions of every set bit.
    function automatic int unsigned ref_index(input int unsigned v, input int n, input bit msb0);
        int unsigned r = 0;
        for (int p = 0; p < n; p++)
            if ((v >> p) & 1) r |= msb0 ? (n - 1 - p) : p;
        return r;
    endfunction

    // Apply an 8-bit vector, check combinational outputs, then registered ones.
    task automatic drive8(input logic [7:0] v);
        int unsigned el, em;
        bit ea, emh;
        @(negedge clk);
        oh8 = v;
        el  = ref_index(v, 8, 1'b0);
        em  = ref_index(v, 8, 1'b1);
        ea  = (v != 0);
        emh = ($countones(v) > 1);
        #1;
        check("l8_index", l8_idx, el);
        check("m8_index", m8_idx, em);
        check("l8_any_set", l8_any, ea);
        check("l8_multi_hot", l8_multi, emh);
        check("m8_multi_hot", m8_multi, emh);
        @(posedge clk);
        #1;
        if (emh) sticky8 = 1'b1;
        check("l8_index_r", l8_idx_r, el);
        check("m8_index_r", m8_idx_r, em);
        check("l8_any_set_r", l8_any_r, ea);
        check("m8_any_set_r", m8_any_r, ea);
        check("l8_error_sticky", l8_err, sticky8);
        check("m8_error_sticky", m8_err, sticky8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; oh8 = '0; oh5 = '0; oh2 = '0; sticky8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_index_r", l8_idx_r, 0);
        check("rst_any_set_r", l8_any_r, 0);
        check("rst_error_sticky", l8_err, 0);
        // Combinational path is live during reset; registers stay cleared.
        oh8 = 8'h04;
        #1;
        check("rst_comb_index", l8_idx, 2);
        @(posedge clk); #1;
        check("rst_hold_index_r", l8_idx_r, 0);
        @(negedge clk);
        reset = 1'b0;

        // Walking one across all bits, both numberings.
        for (int p = 0; p < 8; p++) drive8(8'(1 << p));
        @(negedge clk); oh8 = 8'h01; #1;
        check("msb0_bit0", m8_idx, 7);
        oh8 = 8'h80; #1;
        check("msb0_bit7", m8_idx, 0);

        // All zero.
        drive8(8'h00);

        // Multi-hot: OR of positions, sticky set and held.
        drive8(8'b0000_0110);
        check("mh_index_0110", l8_idx, 3);
        check("mh_sticky_set", l8_err, 1);
        drive8(8'h01);
        check("mh_sticky_hold", l8_err, 1);

        // Randomized mix of one-hot, zero and multi-hot.
        for (int n = 0; n < 60; n++) begin
            int unsigned sel = $urandom_range(0, 9);
            if (sel == 0)      drive8(8'h00);
            else if (sel == 1) drive8(8'($urandom));
            else               drive8(8'(1 << $urandom_range(0, 7)));
        end
        drive8(8'b0000_0110);

        // Asynchronous reset between edges.
        drive8(8'h20);
        check("pre_rst_index_r", l8_idx_r, 5);
        check("pre_rst_sticky", l8_err, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_index_r", l8_idx_r, 0);
        check("async_rst_any_set_r", l8_any_r, 0);
        check("async_rst_sticky", l8_err, 0);
        check("async_rst_m8_sticky", m8_err, 0);
        sticky8 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        drive8(8'h10);

        // Exhaustive sweeps of narrow configurations.
        for (int p = 0; p < 5; p++) begin
            @(negedge clk); oh5 = 5'(1 << p); #1;
            check("l5_index", l5_idx, p);
            check("m5_index", m5_idx, 4 - p);
            check("l5_any_set", l5_any, 1);
            check("l5_multi_hot", l5_multi, 0);
            @(posedge clk); #1;
            check("l5_index_r", l5_idx_r, p);
            check("m5_index_r", m5_idx_r, 4 - p);
        end
        @(negedge clk); oh5 = '0; #1;
        check("l5_zero_any", l5_any, 0);
        check("l5_zero_index", l5_idx, 0);
        for (int p = 0; p < 2; p++) begin
            @(negedge clk); oh2 = 2'(1 << p); #1;
            check("l2_index", l2_idx, p);
            check("l2_any_set", l2_any, 1);
            @(posedge clk); #1;
            check("l2_index_r", l2_idx_r, p);
            check("l2_any_set_r", l2_any_r, 1);
        end
        check("l5_sticky_clear", l5_err, 0);
        check("m5_sticky_clear", m5_err, 0);
        check("l2_sticky_clear", l2_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onehot_to_index.md
Name: onehot_to_index

Overview:
Converts a one-hot (or all-zero) request vector into the binary index of the asserted bit. It is the encoder behind associative lookups such as CAM hit vectors, and arbiter and way-select logic. The primary path is purely combinational, so the index is valid in the same cycle as the one-hot input. A registered copy and a sticky multi-hot error flag are also provided for timing-relaxed consumers and for debug.

Parameters:
NUM_SIGNALS, 4, width of the one-hot input; legal range is 2 or more.
DIRECTION, "LSB0", bit-numbering convention: "LSB0" maps bit i to index i; "MSB0" maps bit i to index NUM_SIGNALS-1-i.
INDEX_WIDTH, $clog2(NUM_SIGNALS), width of the index outputs.

Ports:
clk  input  1  clock; only the registered outputs use it.
reset  input  1  asynchronous, active-high reset.
one_hot  input  NUM_SIGNALS  request vector; expected to be one-hot or all zeros.
index  output  INDEX_WIDTH  combinational binary index of the set bit.
any_set  output  1  combinational OR of one_hot.
multi_hot  output  1  combinational; high when two or more bits of one_hot are set.
index_r  output  INDEX_WIDTH  index registered on the rising edge of clk.
any_set_r  output  1  any_set registered on the rising edge of clk.
error_sticky  output  1  set by multi_hot at a clock edge; cleared only by reset.

Behaviour:
- index is the bitwise OR, over all set bits i, of the index value for i under DIRECTION. There is no priority chain.
  - One-hot input: index is the exact position.
  - All-zero input: index = 0 and any_set = 0. Consumers must qualify index with any_set.
  - Multi-hot input: index is the OR of the individual indices. This is defined and deterministic, but not meaningful. multi_hot = 1.
- Combinational outputs (index, any_set, multi_hot) have zero latency. They have no dependency on clk and are unaffected by reset.
- Registered outputs (index_r, any_set_r) update every rising clk edge with the current index and any_set, giving 1-cycle latency. There is no enable.
- error_sticky is set at a rising clk edge when multi_hot = 1. It stays high until reset.
- Reset is asynchronous and active-high. On assertion, immediately: index_r = 0, any_set_r = 0, error_sticky = 0. Reset asserted mid-stream overrides any pending update. The first capture is at the first rising edge after reset deasserts.
- Width rules:
  - The index computation is done at INDEX_WIDTH bits; i is truncated to INDEX_WIDTH. No truncation occurs when NUM_SIGNALS <= 2^INDEX_WIDTH.
  - Non-power-of-two NUM_SIGNALS is legal; unused index codes are never produced by a one-hot input.
- Simulation only: an assertion fires on a clock edge with multi_hot = 1 while not in reset.

Decomposition:
- No shared package typedefs are required. The DIRECTION string constants "LSB0" and "MSB0" belong in the common defines package if one already exists.
- One natural sub-module: onehot_to_index_comb, holding the pure combinational encoder plus the any_set and multi_hot logic. The top level adds only the registers and the sticky flag.
- multi_hot is computed as (one_hot & (one_hot - 1)) != 0.

Test Plan:
1. NUM_SIGNALS=8, LSB0: walk a single 1 across bits 0..7 → index = 0..7, any_set = 1, multi_hot = 0. One cycle later index_r matches each value.
2. NUM_SIGNALS=8, MSB0: one_hot = 8'b0000_0001 → index = 7; one_hot = 8'b1000_0000 → index = 0.
3. one_hot = 0 → index = 0, any_set = 0. After the next edge: any_set_r = 0, index_r = 0.
4. NUM_SIGNALS=8, one_hot = 8'b0000_0110 → index = 3 (1|2), multi_hot = 1. After the edge, error_sticky = 1 and stays 1 after a return to one-hot inputs.
5. With error_sticky = 1 and index_r = 5, assert reset between clock edges → index_r, any_set_r and error_sticky drop to 0 immediately, without waiting for a clock edge.
6. NUM_SIGNALS=5 (INDEX_WIDTH=3) and NUM_SIGNALS=2 (INDEX_WIDTH=1): exhaustive one-hot sweep → index equals the bit position in every case; any_set = 1 throughout.
